router_sync: RTL and testbench

ROUTER_SYNC -- requirements
Module: router_sync

---
 rtl/router_pkg.sv | 17 +
 rtl/router_sync_timer.sv | 41 ++++
 rtl/router_sync.sv | 107 ++++++++++
 tb/tb_router_sync.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router synchroniser: port address encodings
// and default timer sizing.
package router_pkg;

    localparam int unsigned NUM_PORTS       = 3;
    localparam int unsigned DEFAULT_TIMEOUT = 30;
    localparam int unsigned DEFAULT_CNT_W   = 5;

    // Destination address carried in the header byte
    typedef enum logic [1:0] {
        PORT0        = 2'b00,
        PORT1        = 2'b01,
        PORT2        = 2'b10,
        PORT_INVALID = 2'b11
    } port_addr_e;

endpackage : router_pkg

// File: rtl/router_sync_timer.sv
// Per-port read timeout. Counts consecutive edges where the port holds
// valid data that nobody reads, and emits a one-cycle soft_reset pulse
// when that run reaches TIMEOUT edges. The pulse repeats every TIMEOUT
// edges while the port stays valid and unread.
// Ports:
//   clock, resetn  - system clock, synchronous active-low reset
//   vld            - port FIFO holds data
//   rd             - downstream reader consumes this cycle
//   soft_reset     - registered one-cycle flush pulse
module router_sync_timer #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt;

    // Any read or empty FIFO restarts the run; the terminal count fires
    // the pulse and rewinds so the counter never passes TIMEOUT-1.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
        end
    end

endmodule : router_sync_timer

// File: rtl/router_sync.sv
// Router synchroniser: latches the header destination address, steers the
// FIFO write strobe and full flag by that address, exposes per-port valid
// flags and runs an independent read-timeout per port.
// Ports:
//   clock, resetn            - system clock, synchronous active-low reset
//   detect_add, data_in      - header address capture from router_fsm
//   write_enb_reg            - write request from router_fsm
//   read_enb_0/1/2           - downstream readers
//   empty_0/1/2, full_0/1/2  - port FIFO status
//   write_enb                - one-hot FIFO write strobe (combinational)
//   fifo_full                - full flag of addressed FIFO (combinational)
//   vld_out_0/1/2            - port has data (combinational)
//   soft_reset_0/1/2         - registered per-port timeout pulse
module router_sync
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 detect_add,
    input  logic [1:0]           data_in,
    input  logic                 write_enb_reg,
    input  logic                 read_enb_0,
    input  logic                 read_enb_1,
    input  logic                 read_enb_2,
    input  logic                 empty_0,
    input  logic                 empty_1,
    input  logic                 empty_2,
    input  logic                 full_0,
    input  logic                 full_1,
    input  logic                 full_2,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic                 vld_out_0,
    output logic                 vld_out_1,
    output logic                 vld_out_2,
    output logic                 soft_reset_0,
    output logic                 soft_reset_1,
    output logic                 soft_reset_2
);

    port_addr_e addr_q;

    // Header address capture; a write in the same cycle still uses the old value
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= PORT0;
        end else if (detect_add) begin
            addr_q <= port_addr_e'(data_in);
        end
    end

    // Address-steered write strobe and full flag
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        case (addr_q)
            PORT0: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            PORT1: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            PORT2: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = '0;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_0),
        .rd         (read_enb_0),
        .soft_reset (soft_reset_0)
    );

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_1),
        .rd         (read_enb_1),
        .soft_reset (soft_reset_1)
    );

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_2),
        .rd         (read_enb_2),
        .soft_reset (soft_reset_2)
    );

endmodule : router_sync

// File: tb/tb_router_sync.sv
// Testbench for router_sync: address steering, valid flags, per-port
// read timeouts, reset priority and same-cycle address update.
module tb_router_sync;

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [2:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clock = ~clock;

    router_sync dut (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        full_0 = 1'b1; full_1 = 1'b0; full_2 = 1'b0;
        sb.push_back('{"rst_write_enb", 3'b001});
        sb.push_back('{"rst_fifo_full", 3'b001});
        sb.push_back('{"rst_soft_reset", 3'b000});
        sb.push_back('{"rst_vld_out", 3'b000});
        step(); step();
        e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        e = sb.pop_front(); total++;
        if ({2'b00, fifo_full} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, fifo_full, e.exp[0]); end
        e = sb.pop_front(); total++;
        if ({soft_reset_2, soft_reset_1, soft_reset_0} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, {soft_reset_2, soft_reset_1, soft_reset_0}, e.exp); end
        e = sb.pop_front(); total++;
        if ({vld_out_2, vld_out_1, vld_out_0} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, {vld_out_2, vld_out_1, vld_out_0}, e.exp); end
        resetn = 1'b1; write_enb_reg = 1'b0; full_0 = 1'b0;
        step();
    endtask

    task automatic test_addr_port2();
        detect_add = 1'b1; data_in = 2'b10;
        step();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        sb.push_back('{"p2_write_enb", 3'b100});
        #1; e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        full_2 = 1'b1;
        sb.push_back('{"p2_full_sel", 3'b001});
        #1; e = sb.pop_front(); total++;
        if ({2'b00, fifo_full} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, fifo_full, e.exp[0]); end
        full_2 = 1'b0; full_0 = 1'b1;
        sb.push_back('{"p2_full_other", 3'b000});
        #1; e = sb.pop_front(); total++;
        if ({2'b00, fifo_full} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, fifo_full, e.exp[0]); end
        write_enb_reg = 1'b0; full_0 = 1'b0;
        step();
    endtask

    task automatic test_invalid_addr();
        detect_add = 1'b1; data_in = 2'b11;
        step();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        sb.push_back('{"inv_write_enb", 3'b000});
        sb.push_back('{"inv_fifo_full", 3'b000});
        #1;
        e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        e = sb.pop_front(); total++;
        if ({2'b00, fifo_full} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, fifo_full, e.exp[0]); end
        // port 1 selection while we are here
        detect_add = 1'b1; data_in = 2'b01; write_enb_reg = 1'b0;
        step();
        detect_add = 1'b0; write_enb_reg = 1'b1; full_0 = 1'b0; full_2 = 1'b0;
        sb.push_back('{"p1_write_enb", 3'b010});
        sb.push_back('{"p1_fifo_full", 3'b001});
        #1;
        e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        e = sb.pop_front(); total++;
        if ({2'b00, fifo_full} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, fifo_full, e.exp[0]); end
        write_enb_reg = 1'b0; full_1 = 1'b0;
        step();
    endtask

    task automatic test_vld();
        // readers active so timers stay idle while the flags wiggle
        read_enb_0 = 1'b1; read_enb_1 = 1'b1; read_enb_2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {empty_2, empty_1, empty_0} = 3'(i);
            sb.push_back('{"vld_out", ~(3'(i))});
            step();
            e = sb.pop_front(); total++;
            if ({vld_out_2, vld_out_1, vld_out_0} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, {vld_out_2, vld_out_1, vld_out_0}, e.exp); end
        end
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        step();
    endtask

    task automatic test_timeout_periodic();
        empty_1 = 1'b0; read_enb_1 = 1'b0;
        for (int i = 1; i <= 62; i++) begin
            sb.push_back('{"sr1_periodic", ((i == 30) || (i == 60)) ? 3'b001 : 3'b000});
            step();
            e = sb.pop_front(); total++;
            if ({2'b00, soft_reset_1} !== e.exp) begin bad++; $display("FAIL %s edge=%0d got=%b want=%b", e.name, i, soft_reset_1, e.exp[0]); end
            if (i == 30) begin
                total++;
                if (dut.u_timer_1.cnt !== 5'd0) begin bad++; $display("FAIL cnt1_after_pulse got=%0d want=0", dut.u_timer_1.cnt); end
            end
        end
        empty_1 = 1'b1;
        step();
    endtask

    task automatic test_read_restart();
        empty_0 = 1'b0;
        for (int i = 1; i <= 62; i++) begin
            read_enb_0 = (i == 30);
            sb.push_back('{"sr0_restart", (i == 60) ? 3'b001 : 3'b000});
            step();
            e = sb.pop_front(); total++;
            if ({2'b00, soft_reset_0} !== e.exp) begin bad++; $display("FAIL %s edge=%0d got=%b want=%b", e.name, i, soft_reset_0, e.exp[0]); end
        end
        empty_0 = 1'b1; read_enb_0 = 1'b0;
        step();
    endtask

    task automatic test_independent();
        empty_0 = 1'b0; empty_2 = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            sb.push_back('{"sr_both", (i == 30) ? 3'b101 : 3'b000});
            step();
            e = sb.pop_front(); total++;
            if ({soft_reset_2, soft_reset_1, soft_reset_0} !== e.exp) begin bad++; $display("FAIL %s edge=%0d got=%b want=%b", e.name, i, {soft_reset_2, soft_reset_1, soft_reset_0}, e.exp); end
        end
        empty_0 = 1'b1; empty_2 = 1'b1;
        step();
    endtask

    task automatic test_reset_inflight();
        detect_add = 1'b1; data_in = 2'b10;
        step();
        detect_add = 1'b0; empty_2 = 1'b0; read_enb_2 = 1'b0;
        for (int i = 0; i < 29; i++) step();
        total++;
        if (dut.u_timer_2.cnt !== 5'd29) begin bad++; $display("FAIL cnt2_preload got=%0d want=29", dut.u_timer_2.cnt); end
        resetn = 1'b0; write_enb_reg = 1'b1;
        sb.push_back('{"rst_sr2", 3'b000});
        sb.push_back('{"rst_cnt2", 3'b000});
        sb.push_back('{"rst_addr_we", 3'b001});
        step();
        e = sb.pop_front(); total++;
        if ({2'b00, soft_reset_2} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, soft_reset_2, e.exp[0]); end
        e = sb.pop_front(); total++;
        if (dut.u_timer_2.cnt !== 5'(e.exp)) begin bad++; $display("FAIL %s got=%0d want=%0d", e.name, dut.u_timer_2.cnt, e.exp); end
        e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        total++;
        if (dut.addr_q !== 2'b00) begin bad++; $display("FAIL rst_addr_q got=%b want=00", dut.addr_q); end
        resetn = 1'b1; write_enb_reg = 1'b0; empty_2 = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        // addr_q is 00 from the preceding reset
        detect_add = 1'b1; data_in = 2'b01; write_enb_reg = 1'b1;
        sb.push_back('{"b2b_old_addr", 3'b001});
        #1; e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        sb.push_back('{"b2b_new_addr", 3'b010});
        step();
        detect_add = 1'b0;
        #1; e = sb.pop_front(); total++;
        if (write_enb !== e.exp) begin bad++; $display("FAIL %s got=%b want=%b", e.name, write_enb, e.exp); end
        write_enb_reg = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_addr_port2();
        test_invalid_addr();
        test_vld();
        test_timeout_periodic();
        test_read_restart();
        test_independent();
        test_reset_inflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_router_sync
